hilo_muldiv_unit: RTL
=====================

Name: hilo_muldiv_unit

Overview:
- EX-stage companion to the 32-bit ALU; owns the architectural HI/LO registers.
- Executes MULT, MULTU, MADD, MSUB, DIV, DIVU, MTHI and MTLO.
- Multiply-class ops and moves complete in one cycle. Divides iterate one quotient bit per cycle.
- Busy is the stall request for the hazard unit. Hi/Lo feed the MFHI/MFLO forwarding mux ahead of the ALU B input.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- DIV_CYCLES, WIDTH, number of divide iteration cycles; must equal WIDTH.

Ports:
- Clk  input  1  single clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  op request; accepted only on an edge where Busy=0.
- Op  input  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 DIV, 101 DIVU, 110 MTHI, 111 MTLO.
- A  input  WIDTH  rs operand (dividend, multiplicand, move source).
- B  input  WIDTH  rt operand (divisor, multiplier).
- Busy  output  1  divide in progress.
- Done  output  1  one-cycle pulse when an accepted op has committed to HI/LO.
- DivByZero  output  1  one-cycle pulse, coincident with Done, for a divide with B=0.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, FSM=IDLE. Reset wins over Start on the same edge.
- Reset mid-divide aborts the divide; no partial result is written.
- FSM states: IDLE, DIV.
- Accept rule: Start=1 in IDLE is sampled at edge E0. Start while Busy=1 is ignored; no queueing, no Done.

IDLE, Op = MULT/MULTU/MADD/MSUB/MTHI/MTLO:
- Hi/Lo updated at E0. Done=1 for the cycle after E0. Busy stays 0.
- MULT: {Hi,Lo} = signed A*B, full 64-bit result.
- MULTU: {Hi,Lo} = unsigned A*B.
- MADD: {Hi,Lo} = {Hi,Lo} + signed A*B, modulo 2^64.
- MSUB: {Hi,Lo} = {Hi,Lo} - signed A*B, modulo 2^64.
- MTHI: Hi=A, Lo unchanged. MTLO: Lo=A, Hi unchanged.

IDLE, Op = DIV/DIVU:
- If B=0: at E0 Hi/Lo are left unchanged; Done=1 and DivByZero=1 for the cycle after E0; stay in IDLE.
- Otherwise at E0: latch operand magnitudes (DIV uses absolute values), latch result signs, clear the remainder register, load the iteration counter with DIV_CYCLES-1, set Busy=1, go to DIV.

DIV (restoring division):
- Each edge E1..E32 shifts one dividend bit into the remainder, trial-subtracts the divisor, and records one quotient bit, MSB first.
- At E32 the final bit is resolved. Lo = quotient, Hi = remainder, with signs applied:
  - quotient negated iff the operand signs differ;
  - remainder takes the sign of A.
- Also at E32: Busy drops to 0, Done=1 for one cycle, return to IDLE.
- Total: 32 cycles from accept to result visible.
- Overflow case 0x80000000 / 0xFFFFFFFF under DIV: Lo=0x80000000, Hi=0 (magnitude wrap). No trap.
- Hi/Lo hold their previous values throughout the divide; intermediate state lives in internal registers only.
- A new Start is accepted on the edge after Busy falls. That edge may coincide with the Done cycle.

Decomposition:
- Shared package (processor-wide control definitions, alongside the ALUControl codes):
  - MD_OP_* 3-bit op encodings;
  - WIDTH default;
  - DIV_CYCLES constant.
- One sub-module: div_iter_core, the combinational one-step restoring-divide slice (remainder, divisor, next dividend bit in; new remainder and quotient bit out).
- FSM, counter, sign handling and HI/LO registers stay in hilo_muldiv_unit.

Test Plan:
- MULT A=-4, B=3 -> one cycle later Hi=0xFFFFFFFF, Lo=0xFFFFFFF4, Done pulse, Busy never asserted. Then MULTU A=0xFFFFFFFF, B=2 -> Hi=0x00000001, Lo=0xFFFFFFFE.
- After MTHI A=0, MTLO A=10: MADD A=5, B=7 -> Lo=45, Hi=0. Then MSUB A=5, B=10 -> Lo=0xFFFFFFFB, Hi=0xFFFFFFFF.
- DIVU A=100, B=7 -> Busy high for exactly 32 cycles, Hi/Lo unchanged meanwhile, then Lo=14, Hi=2, single Done pulse. DIV A=-7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV A=55, B=0 -> next cycle Done=1 and DivByZero=1, Busy stays 0, Hi/Lo unchanged.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=100, B=7, with Start+MTLO A=99 at cycle 5 and Reset at cycle 10 -> the MTLO is ignored (Lo unchanged, no extra Done). After Reset: Busy=0, Hi=Lo=0, no Done pulse. A following MTLO A=99 is accepted immediately -> Lo=99.

Source files
------------

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared control definitions for the HI/LO multiply/divide unit:
// op encodings, default operand width, divide iteration count, FSM states.
package hilo_muldiv_unit_pkg;

  localparam int unsigned MD_WIDTH      = 32;
  localparam int unsigned MD_DIV_CYCLES = MD_WIDTH;

  localparam logic [2:0] MD_OP_MULT  = 3'b000;
  localparam logic [2:0] MD_OP_MULTU = 3'b001;
  localparam logic [2:0] MD_OP_MADD  = 3'b010;
  localparam logic [2:0] MD_OP_MSUB  = 3'b011;
  localparam logic [2:0] MD_OP_DIV   = 3'b100;
  localparam logic [2:0] MD_OP_DIVU  = 3'b101;
  localparam logic [2:0] MD_OP_MTHI  = 3'b110;
  localparam logic [2:0] MD_OP_MTLO  = 3'b111;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_DIV  = 1'b1
  } md_state_e;

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the HI/LO unit.
//   master: drives Start/Op/A/B, observes Busy/Done/DivByZero/Hi/Lo
//   slave : the unit itself
interface hilo_muldiv_unit_if
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Op, A, B,
    input  Busy, Done, DivByZero, Hi, Lo
  );

  modport slave (
    input  Start, Op, A, B,
    output Busy, Done, DivByZero, Hi, Lo
  );
endinterface

// File: rtl/hilo_muldiv_unit_div_iter_core.sv
// One combinational step of restoring division.
//   rem_i     : partial remainder (always < divisor_i)
//   divisor_i : divisor magnitude
//   bit_i     : next dividend bit, MSB first
//   rem_o     : updated partial remainder
//   q_bit_o   : quotient bit produced by this step
module div_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // Two guard bits: one for the shifted-in bit, one to catch the borrow.
  logic [WIDTH+1:0] diff;

  always_comb begin
    diff    = {1'b0, rem_i, bit_i} - {2'b00, divisor_i};
    q_bit_o = ~diff[WIDTH+1];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : {rem_i[WIDTH-2:0], bit_i};
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit. Multiply-class ops and moves commit in one
// cycle; DIV/DIVU iterate one quotient bit per cycle with Busy asserted.
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : slave side of hilo_muldiv_unit_if (Start/Op/A/B in,
//           Busy/Done/DivByZero/Hi/Lo out, all outputs registered)
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = MD_WIDTH,
  parameter int unsigned DIV_CYCLES = WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  hilo_muldiv_unit_if.slave  bus
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [W2-1:0]    prod_s;
  logic [W2-1:0]    prod_u;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quot;
  logic             a_neg;
  logic             b_neg;

  // One restoring-divide step; dividend bits leave dvd_q MSB first while
  // quotient bits enter at the LSB, so dvd_q ends up holding the quotient.
  div_iter_core #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (rem_q),
    .divisor_i (dsr_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Low 2W bits of the product of sign-extended operands is the signed product.
  always_comb begin
    prod_s = W2'({{WIDTH{bus.A[WIDTH-1]}}, bus.A} * {{WIDTH{bus.B[WIDTH-1]}}, bus.B});
    prod_u = W2'({{WIDTH{1'b0}}, bus.A} * {{WIDTH{1'b0}}, bus.B});
  end

  // Next-state, HI/LO and divide datapath.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    quot    = {dvd_q[WIDTH-2:0], step_q};
    a_neg   = (bus.Op == MD_OP_DIV) & bus.A[WIDTH-1];
    b_neg   = (bus.Op == MD_OP_DIV) & bus.B[WIDTH-1];

    case (state_q)
      MD_IDLE: begin
        if (bus.Start) begin
          done_d = 1'b1;
          case (bus.Op)
            MD_OP_MULT:  {hi_d, lo_d} = prod_s;
            MD_OP_MULTU: {hi_d, lo_d} = prod_u;
            MD_OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            MD_OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            MD_OP_MTHI:  hi_d = bus.A;
            MD_OP_MTLO:  lo_d = bus.A;
            default: begin
              // DIV / DIVU
              if (bus.B == '0) begin
                dbz_d = 1'b1;
              end else begin
                done_d  = 1'b0;
                dvd_d   = a_neg ? -bus.A : bus.A;
                dsr_d   = b_neg ? -bus.B : bus.B;
                rem_d   = '0;
                cnt_d   = CNT_W'(DIV_CYCLES - 1);
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
                busy_d  = 1'b1;
                state_d = MD_DIV;
              end
            end
          endcase
        end
      end

      MD_DIV: begin
        rem_d = step_rem;
        dvd_d = quot;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          // Final bit resolved this edge: apply signs and commit.
          lo_d    = negq_q ? -quot : quot;
          hi_d    = negr_q ? -step_rem : step_rem;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = MD_IDLE;
        end
      end

      default: state_d = MD_IDLE;
    endcase
  end

  // State and output registers; reset also aborts any divide in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= MD_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;

endmodule
